ibex_vec_mac: RTL

//  Pipelined, multi-lane signed vector add/sub/multiply/multiply-accumulate unit with per-lane

---
 rtl/ibex_vec_mac_pkg.sv | 39 +++
 rtl/ibex_vec_mac_lane.sv | 124 ++++++++++++
 rtl/ibex_vec_mac.sv | 96 +++++++++
 3 files changed

// File: rtl/ibex_vec_mac_pkg.sv
// ============================================================================
// Module   : ibex_vec_mac_pkg
// Brief    : Shared operator encoding and saturation helper for ibex_vec_mac.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ibex_vec_mac_pkg;

    localparam int VMAC_OP_W = 3;

    typedef enum logic [VMAC_OP_W-1:0] {
        VMAC_ADD   = 3'd0,
        VMAC_SUB   = 3'd1,
        VMAC_MUL   = 3'd2,
        VMAC_MAC   = 3'd3,
        VMAC_CLR   = 3'd4,
        VMAC_RDACC = 3'd5
    } vmac_op_e;

    // Clamp a signed value into the range of a WIDTH-bit two's complement number.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] val,
                                                     input int unsigned     width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (val > hi) begin
            return hi;
        end else if (val < lo) begin
            return lo;
        end else begin
            return val;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/ibex_vec_mac_lane.sv
// ============================================================================
// Module   : ibex_vec_mac_lane
// Brief    : One lane: S1 operand/product registers, S2 adder, accumulator.
//            Saturating arithmetic when IBEX_VEC_MAC_SAT_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ibex_vec_mac_lane
    import ibex_vec_mac_pkg::*;
#(
    parameter int ELEM_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              s1_en_i,
    input  logic              s2_en_i,
    input  vmac_op_e          op_s1_i,
    input  logic [ELEM_W-1:0] a_i,
    input  logic [ELEM_W-1:0] b_i,
    output logic [ACC_W-1:0]  result_o,
    output logic              sat_o
);

`ifdef IBEX_VEC_MAC_SAT_EN
    localparam int SUM_W = ACC_W + 1;
`else
    localparam int SUM_W = ACC_W;
`endif

    logic signed [ACC_W-1:0]    a_q, b_q;
    logic signed [2*ELEM_W-1:0] prod_q;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic        [ACC_W-1:0]    res_q, res_d;
    logic                       sat_q, sat_d;

    logic signed [SUM_W-1:0] w_sum;
    logic                    w_can_sat;
    logic                    w_acc_we;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
        end else if (s1_en_i) begin
            a_q    <= ACC_W'($signed(a_i));
            b_q    <= ACC_W'($signed(b_i));
            prod_q <= $signed(a_i) * $signed(b_i);
        end
    end

    // Undefined opcodes fall into the ADD arm and leave the accumulator alone.
    always_comb begin
        w_sum     = SUM_W'(a_q) + SUM_W'(b_q);
        w_can_sat = 1'b1;
        w_acc_we  = 1'b0;
        case (op_s1_i)
            VMAC_SUB:   w_sum = SUM_W'(a_q) - SUM_W'(b_q);
            VMAC_MUL: begin
                w_sum     = SUM_W'(prod_q);
                w_can_sat = 1'b0;
            end
            VMAC_MAC: begin
                w_sum    = SUM_W'(acc_q) + SUM_W'(prod_q);
                w_acc_we = 1'b1;
            end
            VMAC_CLR: begin
                w_sum     = '0;
                w_can_sat = 1'b0;
                w_acc_we  = 1'b1;
            end
            VMAC_RDACC: begin
                w_sum     = SUM_W'(acc_q);
                w_can_sat = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef IBEX_VEC_MAC_SAT_EN
    logic signed [63:0] w_wide;
    logic signed [63:0] w_clamped;
    always_comb begin
        w_wide    = 64'(w_sum);
        w_clamped = sat_clamp(w_wide, ACC_W);
        res_d     = w_clamped[ACC_W-1:0];
        sat_d     = w_can_sat && (w_clamped != w_wide);
    end
`else
    always_comb begin
        res_d = w_sum[ACC_W-1:0];
        sat_d = 1'b0 & w_can_sat;
    end
`endif

    always_comb begin
        acc_d = acc_q;
        if (s2_en_i && w_acc_we) begin
            acc_d = $signed(res_d);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_q <= '0;
            sat_q <= 1'b0;
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
            if (s2_en_i) begin
                res_q <= res_d;
                sat_q <= sat_d;
            end
        end
    end

    assign result_o = res_q;
    assign sat_o    = sat_q;

endmodule

`default_nettype wire

// File: rtl/ibex_vec_mac.sv
// ============================================================================
// Module   : ibex_vec_mac
// Brief    : Two-stage multi-lane signed vector ADD/SUB/MUL/MAC unit with
//            per-lane accumulators. Optional saturation: IBEX_VEC_MAC_SAT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ibex_vec_mac
    import ibex_vec_mac_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int ELEM_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [VMAC_OP_W-1:0]    operator_i,
    input  logic [LANES*ELEM_W-1:0] operand_a_i,
    input  logic [LANES*ELEM_W-1:0] operand_b_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [LANES*ACC_W-1:0]  result_o,
    output logic [LANES-1:0]        sat_o
);

    if (ACC_W < 2*ELEM_W + 1) begin : g_cfg_err
        $error("ibex_vec_mac: ACC_W must be >= 2*ELEM_W+1");
    end

    logic     s1_v_q, s1_v_d;
    logic     s2_v_q, s2_v_d;
    vmac_op_e op_s1_q;

    logic w_s2_free;
    logic w_s1_load;
    logic w_s2_load;

    assign w_s2_free  = !s2_v_q || out_ready_i;
    assign in_ready_o = !s1_v_q || w_s2_free;
    assign w_s1_load  = in_valid_i && in_ready_o;
    assign w_s2_load  = s1_v_q && w_s2_free;

    always_comb begin
        s1_v_d = s1_v_q;
        s2_v_d = s2_v_q;
        if (w_s1_load) begin
            s1_v_d = 1'b1;
        end else if (w_s2_load) begin
            s1_v_d = 1'b0;
        end
        if (w_s2_load) begin
            s2_v_d = 1'b1;
        end else if (out_ready_i) begin
            s2_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_v_q  <= 1'b0;
            s2_v_q  <= 1'b0;
            op_s1_q <= VMAC_ADD;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            if (w_s1_load) begin
                op_s1_q <= vmac_op_e'(operator_i);
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        ibex_vec_mac_lane #(
            .ELEM_W (ELEM_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .s1_en_i  (w_s1_load),
            .s2_en_i  (w_s2_load),
            .op_s1_i  (op_s1_q),
            .a_i      (operand_a_i[l*ELEM_W +: ELEM_W]),
            .b_i      (operand_b_i[l*ELEM_W +: ELEM_W]),
            .result_o (result_o[l*ACC_W +: ACC_W]),
            .sat_o    (sat_o[l])
        );
    end

    assign out_valid_o = s2_v_q;

endmodule

`default_nettype wire
